spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sclk half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  transfer request, sampled while busy=0.
REQ-005 SHALL have port tx_data  input  8  byte to send, captured in the cycle start is accepted.
REQ-006 SHALL have port busy  output  1  high from the cycle after acceptance until done.
REQ-007 SHALL have port done  output  1  one-cycle pulse at transfer end.
REQ-008 SHALL have port rx_data  output  8  byte received, updated in the done cycle, held otherwise.
REQ-009 SHALL have port sclk  output  1  SPI clock, idle low (mode 0).
REQ-010 SHALL have port cs_n  output  1  chip select, active-low.
REQ-011 SHALL have port mosi  output  1  serial data out.
REQ-012 SHALL have port miso  input  1  serial data in.

Function
REQ-013 SHALL implement states IDLE, SETUP, XFER, HOLD; IDLE->SETUP on start&&!busy, SETUP->XFER after CLK_DIV cycles, XFER->HOLD after 8th sclk falling edge, HOLD->IDLE after CLK_DIV cycles.
REQ-014 SHALL, on acceptance (cycle 0), drive cs_n=0, busy=1, and mosi=first data bit from cycle 1.
REQ-015 SHALL hold sclk low for CLK_DIV cycles of SETUP, then toggle sclk every CLK_DIV cycles for exactly 8 full periods (16 edges).
REQ-016 SHALL sample miso into the receive shift register on each sclk rising edge (sampled value from the clk cycle in which sclk goes high).
REQ-017 SHALL present the next transmit bit on mosi in the cycle each sclk falling edge occurs; mosi after the 8th falling edge SHALL be 0.
REQ-018 SHALL, in the cycle ending HOLD (cycle 18*CLK_DIV+1), drive cs_n=1, busy=0, done=1, rx_data=received byte.
REQ-019 SHALL ignore start while busy=1; tx_data changes during a transfer SHALL not affect it.
REQ-020 SHALL accept start in the done cycle (busy=0), giving back-to-back transfers with cs_n high for exactly one clk cycle.
REQ-021 SHALL keep sclk=0, cs_n=1, mosi=0 in IDLE.
REQ-022 SHALL use an 8-bit half-period counter and 4-bit edge counter; no counter wraps within a transfer.

Reset
REQ-023 SHALL, on rst=1 at a clk edge, set state=IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=8'h00, shift registers and counters=0.
REQ-024 SHALL, on reset mid-transfer, abort without done pulse; start sampled in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-025 SHALL, when macro SPI_MASTER_LSB_FIRST_EN is defined, transmit tx_data[0] first and place the first received bit in rx_data[0].
REQ-026 SHALL, when SPI_MASTER_LSB_FIRST_EN is undefined, transmit tx_data[7] first and place the first received bit in rx_data[7] (MSB first).

Verification
REQ-027 SHALL cover: CLK_DIV=2, start with tx_data=8'hA5, miso loopback from an MSB-first mode-0 model returning 8'h3C -> mosi bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; done at cycle 37.
REQ-028 SHALL cover: start held high while busy, tx_data changed to 8'hFF mid-transfer -> single transfer of original byte, one done pulse.
REQ-029 SHALL cover: start in done cycle with tx_data=8'h81 -> cs_n high exactly 1 cycle, second transfer sends 8'h81.
REQ-030 SHALL cover: rst=1 after 4th sclk rise -> next cycle cs_n=1, sclk=0, busy=0, rx_data=8'h00, no done.
REQ-031 SHALL cover: CLK_DIV=1, tx_data=8'h00, miso=1 -> sclk period 2 clk, rx_data=8'hFF, done at cycle 19.
REQ-032 SHALL cover: SPI_MASTER_LSB_FIRST_EN defined, tx_data=8'h01 -> first mosi bit 1, rest 0.

Source files
------------

// File: rtl/spi_master.sv
// spi_master: single-byte SPI mode-0 master (sclk idle low, sample on rise,
// shift on fall). sclk half-period is CLK_DIV clk cycles.
// Optional build macro SPI_MASTER_LSB_FIRST_EN selects LSB-first bit order;
// the default build is MSB-first.
// Transfer timeline, counted from the acceptance cycle (cycle 0):
//   SETUP  cycles 1 .. D           cs_n low, sclk low, first bit on mosi
//   XFER   cycles D+1 .. 17D       16 sclk edges, one every D cycles
//   HOLD   cycles 17D+1 .. 18D     sclk low, cs_n still low
//   done   cycle 18D+1             back in IDLE, done pulse, rx_data valid
module spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  // Last value of the half-period counter before an sclk edge is due.
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     r_state;
  logic [7:0] r_div_cnt;
  logic [3:0] r_edge_cnt;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic [7:0] r_rx_data;
  logic       r_sclk;
  logic       r_cs_n;
  logic       r_mosi;
  logic       r_busy;
  logic       r_done;

  // Bit-order dependent views of the shift registers.
  logic       w_first_bit;
  logic [7:0] w_tx_load;
  logic       w_tx_bit;
  logic [7:0] w_tx_next;
  logic [7:0] w_rx_next;
  logic       w_div_end;

`ifdef SPI_MASTER_LSB_FIRST_EN
  assign w_first_bit = tx_data[0];
  assign w_tx_load   = {1'b0, tx_data[7:1]};
  assign w_tx_bit    = r_tx_shift[0];
  assign w_tx_next   = {1'b0, r_tx_shift[7:1]};
  assign w_rx_next   = {miso, r_rx_shift[7:1]};
`else
  assign w_first_bit = tx_data[7];
  assign w_tx_load   = {tx_data[6:0], 1'b0};
  assign w_tx_bit    = r_tx_shift[7];
  assign w_tx_next   = {r_tx_shift[6:0], 1'b0};
  assign w_rx_next   = {r_rx_shift[6:0], miso};
`endif

  assign w_div_end = (r_div_cnt == DIV_LAST);

  // Transfer sequencer: state, counters, shift registers and all outputs.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking assignments would make order matter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_div_cnt  <= 8'd0;
      r_edge_cnt <= 4'd0;
      r_tx_shift <= 8'h00;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_sclk     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // busy is always low here, so start alone means acceptance.
          if (start) begin
            r_state    <= SETUP;
            r_busy     <= 1'b1;
            r_cs_n     <= 1'b0;
            r_mosi     <= w_first_bit;
            r_tx_shift <= w_tx_load;
            r_rx_shift <= 8'h00;
            r_div_cnt  <= 8'd0;
            r_edge_cnt <= 4'd0;
          end
        end
        SETUP: begin
          if (w_div_end) begin
            // First rising edge: capture the first miso bit.
            r_div_cnt  <= 8'd0;
            r_sclk     <= 1'b1;
            r_rx_shift <= w_rx_next;
            r_edge_cnt <= 4'd0;
            r_state    <= XFER;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end
        XFER: begin
          if (w_div_end) begin
            r_div_cnt <= 8'd0;
            // Edge count 15 means edges 2..16 are done and the low half
            // period after the last falling edge has elapsed.
            if (r_edge_cnt == 4'd15) begin
              r_state <= HOLD;
            end else begin
              r_edge_cnt <= r_edge_cnt + 4'd1;
              r_sclk     <= ~r_sclk;
              if (r_sclk) begin
                // Falling edge: present the next bit (zero after the last).
                r_mosi     <= w_tx_bit;
                r_tx_shift <= w_tx_next;
              end else begin
                r_rx_shift <= w_rx_next;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end
        HOLD: begin
          if (w_div_end) begin
            r_div_cnt <= 8'd0;
            r_state   <= IDLE;
            r_cs_n    <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_mosi    <= 1'b0;
            r_rx_data <= r_rx_shift;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign cs_n    = r_cs_n;
  assign mosi    = r_mosi;

endmodule
